seq_arbiter: RTL and testbench

SEQ_ARBITER -- requirements
Module: seq_arbiter

---
 rtl/seq_arbiter_if.sv | 31 +++
 rtl/seq_arbiter.sv | 110 +++++++++++
 tb/tb_seq_arbiter.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/seq_arbiter_if.sv
// Bundle between two job requesters, the serializing arbiter and a shared
// sequence detector; the arbiter sits on the slave side.
interface seq_arbiter_if #(
  parameter int WIDTH = 8,
  parameter int CW    = 5
);
  logic [1:0]       req;
  logic [WIDTH-1:0] data0;
  logic [WIDTH-1:0] data1;
  logic [1:0]       gnt;
  logic             det_w;
  logic             det_rst;
  logic             det_z;
  logic             busy;
  logic             done;
  logic             done_id;
  logic [CW-1:0]    hit_count;
  logic [2:0]       state;

  // req[i] is held by requester i until it observes gnt[i]; the one-cycle
  // gnt pulse is also the cycle in which data<i> is captured.
  modport master (
    output req, data0, data1, det_z,
    input  gnt, det_w, det_rst, busy, done, done_id, hit_count, state
  );

  modport slave (
    input  req, data0, data1, det_z,
    output gnt, det_w, det_rst, busy, done, done_id, hit_count, state
  );
endinterface

// File: rtl/seq_arbiter.sv
// Round-robin arbiter that serializes a granted job word LSB first into a
// shared sequence detector and counts the detector's z hits for that job.
module seq_arbiter #(
  parameter int WIDTH = 8,
  parameter int CW    = 5
) (
  input logic         clk,
  input logic         reset,
  seq_arbiter_if.slave bus
);
  localparam int BW = $clog2(WIDTH);
  localparam logic [BW-1:0] LAST = BW'(WIDTH - 1);

  typedef enum logic [2:0] {IDLE, CLEAR, SHIFT, FLUSH, DONE} state_t;

  state_t           state, next;
  logic [WIDTH-1:0] shreg;
  logic [BW-1:0]    bcnt;
  logic [CW-1:0]    acc;
  logic [CW-1:0]    hit_q;
  logic             cur_id;
  logic             last_id;
  logic             done_id_q;
  logic             sel;
  logic [1:0]       gnt_c;
  logic             det_w_c;
  logic             done_c;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next;
  end

  always_comb begin
    next    = state;
    sel     = 1'b0;
    gnt_c   = 2'b00;
    det_w_c = 1'b0;
    done_c  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.req != 2'b00) begin
          // Contention goes to whichever requester did not finish last.
          sel   = (bus.req == 2'b11) ? ~last_id : bus.req[1];
          gnt_c = sel ? 2'b10 : 2'b01;
          next  = CLEAR;
        end
      end
      CLEAR: next = SHIFT;
      SHIFT: begin
        det_w_c = shreg[0];
        if (bcnt == LAST) next = FLUSH;
      end
      FLUSH: next = DONE;
      DONE: begin
        done_c = 1'b1;
        next   = IDLE;
      end
      default: next = IDLE;
    endcase
  end

  // The detector's z lags its w by one cycle, so samples start at the second
  // SHIFT cycle and the final one lands in FLUSH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg     <= '0;
      bcnt      <= '0;
      acc       <= '0;
      hit_q     <= '0;
      cur_id    <= 1'b0;
      done_id_q <= 1'b0;
      last_id   <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req != 2'b00) begin
            shreg  <= sel ? bus.data1 : bus.data0;
            cur_id <= sel;
          end
        end
        CLEAR: begin
          bcnt <= '0;
          acc  <= '0;
        end
        SHIFT: begin
          shreg <= shreg >> 1;
          bcnt  <= bcnt + BW'(1);
          if (bcnt != '0) acc <= acc + CW'(bus.det_z);
        end
        FLUSH: begin
          acc       <= acc + CW'(bus.det_z);
          hit_q     <= acc + CW'(bus.det_z);
          done_id_q <= cur_id;
        end
        DONE: last_id <= cur_id;
        default: ;
      endcase
    end
  end

  assign bus.gnt       = reset ? 2'b00 : gnt_c;
  assign bus.det_w     = det_w_c;
  assign bus.det_rst   = reset | (state == CLEAR);
  assign bus.busy      = (state != IDLE);
  assign bus.done      = done_c;
  assign bus.done_id   = done_id_q;
  assign bus.hit_count = hit_q;
  assign bus.state     = state;
endmodule

// File: tb/tb_seq_arbiter.sv
// Directed bench for seq_arbiter: grant/serialize timing, round robin, hit
// counting with forced z or a small run-of-ones detector, and mid-job reset.
module tb_seq_arbiter;
  logic clk;
  logic reset;
  int   total;
  int   bad;
  int   cyc;
  int   gnt_cyc;
  logic use_det;
  logic z_force;
  logic [1:0] dstate;
  logic z_model;

  seq_arbiter_if #(.WIDTH(8), .CW(5)) bus ();

  seq_arbiter #(.WIDTH(8), .CW(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Moore detector: z=1 once w has been 1 on two or more consecutive edges.
  always @(posedge clk) begin
    if (bus.det_rst)  dstate <= 2'd0;
    else if (bus.det_w) dstate <= (dstate == 2'd2) ? 2'd2 : dstate + 2'd1;
    else              dstate <= 2'd0;
  end
  assign z_model    = (dstate == 2'd2);
  assign bus.det_z  = use_det ? z_model : z_force;

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  // scoreboard
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // drivers
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    check("rst_gnt", bus.gnt, 2'b00);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_done", bus.done, 1'b0);
    check("rst_done_id", bus.done_id, 1'b0);
    check("rst_hits", bus.hit_count, 5'd0);
    check("rst_det_rst", bus.det_rst, 1'b1);
    check("rst_det_w", bus.det_w, 1'b0);
    check("rst_state", bus.state, 3'd0);
    step();
    step();
    reset = 1'b0;
    step();
  endtask

  // Called at posedge+1 in IDLE; returns at posedge+1 in the cycle after DONE.
  // zmode: 0 z=0, 1 z=1 throughout, 2 z=1 only in FLUSH, 3 z=1 only in first SHIFT.
  task automatic run_job(input logic [1:0] reqv, input logic [7:0] d0, input logic [7:0] d1,
                         input logic exp_id, input logic [7:0] word, input int zmode,
                         input logic [4:0] exp_hits, input bit gap, input bit tog);
    bus.req   = reqv;
    bus.data0 = d0;
    bus.data1 = d1;
    z_force   = (zmode == 1);
    #1;
    check("gnt", bus.gnt, exp_id ? 2'b10 : 2'b01);
    check("busy_idle", bus.busy, 1'b0);
    if (gap) check("gap", cyc - gnt_cyc, 12);
    gnt_cyc = cyc;
    step();
    bus.req[exp_id] = 1'b0;
    bus.data0 = ~d0;
    bus.data1 = ~d1;
    #1;
    check("clr_det_rst", bus.det_rst, 1'b1);
    check("clr_det_w", bus.det_w, 1'b0);
    check("clr_busy", bus.busy, 1'b1);
    check("clr_gnt", bus.gnt, 2'b00);
    for (int i = 0; i < 8; i++) begin
      step();
      z_force = (zmode == 1) || (zmode == 3 && i == 0);
      if (tog) begin
        if (i == 2) bus.req[1] = 1'b1;
        if (i == 4) bus.req[1] = 1'b0;
        if (i == 5) bus.req[1] = 1'b1;
      end
      #1;
      check($sformatf("det_w%0d", i), bus.det_w, word[i]);
      check("shift_gnt", bus.gnt, 2'b00);
      check("shift_busy", bus.busy, 1'b1);
      check("shift_det_rst", bus.det_rst, 1'b0);
    end
    step();
    z_force = (zmode == 1) || (zmode == 2);
    #1;
    check("flush_det_w", bus.det_w, 1'b0);
    check("flush_done", bus.done, 1'b0);
    step();
    z_force = 1'b0;
    #1;
    check("done", bus.done, 1'b1);
    check("done_id", bus.done_id, exp_id);
    check("hit_count", bus.hit_count, exp_hits);
    check("done_gnt", bus.gnt, 2'b00);
    step();
    check("done_after", bus.done, 1'b0);
    check("done_id_hold", bus.done_id, exp_id);
    check("hits_hold", bus.hit_count, exp_hits);
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    cyc       = 0;
    gnt_cyc   = 0;
    use_det   = 1'b0;
    z_force   = 1'b0;
    bus.req   = 2'b00;
    bus.data0 = '0;
    bus.data1 = '0;

    do_reset();
    check("idle_gnt", bus.gnt, 2'b00);

    // single requester, B5 serialized LSB first, no hits
    run_job(2'b01, 8'hB5, 8'h00, 1'b0, 8'hB5, 0, 5'd0, 1'b0, 1'b0);

    // round robin with both held, starting from requester 0 after reset
    do_reset();
    run_job(2'b11, 8'hB5, 8'h3C, 1'b0, 8'hB5, 0, 5'd0, 1'b0, 1'b0);
    run_job(2'b11, 8'hB5, 8'h3C, 1'b1, 8'h3C, 0, 5'd0, 1'b1, 1'b0);
    run_job(2'b11, 8'h96, 8'h3C, 1'b0, 8'h96, 0, 5'd0, 1'b1, 1'b0);
    run_job(2'b11, 8'h96, 8'hE1, 1'b1, 8'hE1, 0, 5'd0, 1'b1, 1'b0);

    // forced z patterns: all-ones, FLUSH only, first SHIFT only
    run_job(2'b01, 8'h5A, 8'h00, 1'b0, 8'h5A, 1, 5'd8, 1'b1, 1'b0);
    run_job(2'b01, 8'h5A, 8'h00, 1'b0, 8'h5A, 2, 5'd1, 1'b1, 1'b0);
    run_job(2'b01, 8'h5A, 8'h00, 1'b0, 8'h5A, 3, 5'd0, 1'b1, 1'b0);

    // run-of-ones detector in the loop
    use_det = 1'b1;
    run_job(2'b01, 8'hFF, 8'h00, 1'b0, 8'hFF, 0, 5'd7, 1'b1, 1'b0);
    run_job(2'b01, 8'h00, 8'hFF, 1'b0, 8'h00, 0, 5'd0, 1'b1, 1'b0);
    run_job(2'b01, 8'h6E, 8'h00, 1'b0, 8'h6E, 0, 5'd3, 1'b1, 1'b0);
    use_det = 1'b0;

    // req toggles mid-job are ignored; pending req wins right after DONE
    run_job(2'b01, 8'hC3, 8'h00, 1'b0, 8'hC3, 0, 5'd0, 1'b1, 1'b1);
    check("pending_gnt", bus.gnt, 2'b10);
    run_job(2'b10, 8'h00, 8'h81, 1'b1, 8'h81, 1, 5'd8, 1'b1, 1'b0);

    // reset during SHIFT aborts the job
    bus.req   = 2'b01;
    bus.data0 = 8'hA5;
    #1;
    check("abort_gnt", bus.gnt, 2'b01);
    step();
    bus.req = 2'b00;
    repeat (4) step();
    check("abort_busy_pre", bus.busy, 1'b1);
    reset   = 1'b1;
    bus.req = 2'b10;
    #1;
    check("abort_busy", bus.busy, 1'b0);
    check("abort_det_rst", bus.det_rst, 1'b1);
    check("abort_det_w", bus.det_w, 1'b0);
    check("abort_gnt_rst", bus.gnt, 2'b00);
    check("abort_hits", bus.hit_count, 5'd0);
    check("abort_done_id", bus.done_id, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step();
      check("abort_no_done", bus.done, 1'b0);
    end
    reset = 1'b0;
    #1;
    check("release_gnt", bus.gnt, 2'b10);
    run_job(2'b10, 8'h00, 8'h4B, 1'b1, 8'h4B, 0, 5'd0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step();
      check("idle_tail_done", bus.done, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
